uart_tx_arbiter: RTL and testbench

//   Round-robin arbiter that shares one uart_transmitter among NUM_REQ byte requesters.
//   - Accepts one byte per grant over a valid/ready handshake.
//   - Issues a one-cycle tx_start with stable data to the transmitter.
//   - Holds off the next grant until the transmitter reports tx_done.
//   - Sits between on-chip producers (status, debug, log sources) and the single UART TX pin.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional WAIT watchdog enabled by defining TX_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 120000,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         uart_data_in,
  output logic                      uart_tx_start,
  input  logic                      uart_tx_done,
  output logic                      busy,
  output logic [GW-1:0]             grant_id,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                tout_q, tout_d;
  logic                done_prev_q;
  logic                done_rise;
  logic                sel_found;
  logic [GW-1:0]       sel_idx;
  logic [GW-1:0]       sel_next;

`ifdef TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]       cnt_q, cnt_d;
`endif

  assign done_rise = uart_tx_done & ~done_prev_q;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    logic [GW-1:0] j;
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[j]) begin
        sel_found = 1'b1;
        sel_idx   = j;
      end
    end
    if (sel_idx == GW'(NUM_REQ - 1)) begin
      sel_next = '0;
    end else begin
      sel_next = sel_idx + 1'b1;
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ready_d = '0;
    data_d  = data_q;
    start_d = 1'b0;
    tout_d  = 1'b0;
`ifdef TX_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          ptr_d   = sel_next;
          ready_d = NUM_REQ'(1) << sel_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        data_d  = req_data[int'(grant_q)*DATA_W +: DATA_W];
        start_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
`ifdef TX_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          state_d = S_IDLE;
`ifdef TX_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ready_q     <= '0;
      data_q      <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      tout_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      tout_q      <= tout_d;
      done_prev_q <= uart_tx_done;
    end
  end

`ifdef TX_TIMEOUT_EN
  // WAIT watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign timeout_err = tout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_ready     = ready_q;
  assign uart_data_in  = data_q;
  assign uart_tx_start = start_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter.
// Timeout step runs only when TX_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  uart_data_in;
  logic        uart_tx_start;
  logic        uart_tx_done = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_W(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .uart_data_in(uart_data_in),
    .uart_tx_start(uart_tx_start),
    .uart_tx_done(uart_tx_done),
    .busy(busy),
    .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         n_start = 0;
  int         tx_cnt = 0;
  int         tx_delay = 3;
  bit         done_hold = 0;
  bit         tx_mute = 0;
  bit         seen3 = 0;
  logic [3:0] keep = '0;
  logic [3:0] prev_ready = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int i, input logic [7:0] d);
    exp_t e;
    req_data[i*8 +: 8] = d;
    req_valid[i] = 1'b1;
    e.g = 2'(i);
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    logic [3:0] oh;
    @(posedge clk);
    #1;
    if (!done_hold) uart_tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0 && !tx_mute) uart_tx_done = 1'b1;
    end
    if (req_ready != 4'b0) begin
      oh = 4'b0001 << grant_id;
      chk("ready_onehot", req_ready, oh);
      chk("ready_1cyc", prev_ready, 4'b0);
      if (req_ready[3]) seen3 = 1;
      for (int i = 0; i < 4; i++)
        if (req_ready[i] && !keep[i]) req_valid[i] = 1'b0;
    end
    prev_ready = req_ready;
    if (uart_tx_start) begin
      n_start++;
      tx_cnt = tx_delay;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_grant", grant_id, e.g);
        chk("sb_data", uart_data_in, e.d);
      end
    end
  endtask

  task automatic wait_start();
    int n0;
    n0 = n_start;
    for (int k = 0; k < 300 && n_start == n0; k++) cyc();
    chk("start_seen", n_start != n0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && busy !== 1'b0; k++) cyc();
    chk("idle_seen", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    keep = '0;
    uart_tx_done = 1'b0;
    tx_cnt = 0;
    done_hold = 0;
    tx_mute = 0;
    sb.delete();
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", uart_tx_start, 0);
    chk("rst_data", uart_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_tout", timeout_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_ready = '0;
  endtask

  initial begin
    int n0;
    int k;
    #1;
    do_reset();
    cyc();

    // Single requester latency and data hold
    req(1, 8'hA5);
    cyc();
    chk("t1_ready", req_ready, 4'b0010);
    chk("t1_gid", grant_id, 1);
    chk("t1_busy", busy, 1);
    chk("t1_nostart", uart_tx_start, 0);
    cyc();
    chk("t1_start", uart_tx_start, 1);
    chk("t1_data", uart_data_in, 8'hA5);
    cyc();
    chk("t1_start_1cyc", uart_tx_start, 0);
    chk("t1_busy_wait", busy, 1);
    wait_idle();
    chk("t1_hold", uart_data_in, 8'hA5);
    chk("t1_count", n_start, 1);

    // All four at once from a fresh pointer
    do_reset();
    n0 = n_start;
    req(0, 8'h10);
    req(1, 8'h11);
    req(2, 8'h12);
    req(3, 8'h13);
    repeat (4) wait_start();
    wait_idle();
    chk("t2_count", n_start - n0, 4);
    chk("t2_sb", sb.size(), 0);

    // Continuous 0 and 2: alternation and wrap
    n0 = n_start;
    keep = 4'b0101;
    req(0, 8'h30);
    req(2, 8'h32);
    req(0, 8'h30);
    req(2, 8'h32);
    repeat (4) wait_start();
    req_valid = '0;
    keep = '0;
    wait_idle();
    repeat (5) cyc();
    chk("t3_count", n_start - n0, 4);
    chk("t3_sb", sb.size(), 0);

    // Brief req3 during WAIT is never granted
    seen3 = 0;
    n0 = n_start;
    req(0, 8'h40);
    wait_start();
    cyc();
    req_valid[3] = 1'b1;
    cyc();
    req_valid[3] = 1'b0;
    wait_idle();
    repeat (10) cyc();
    chk("t4_count", n_start - n0, 1);
    chk("t4_no3", seen3, 0);

    // A done level left high must not end the next WAIT
    done_hold = 1;
    req(2, 8'h22);
    wait_start();
    wait_idle();
    tx_mute = 1;
    req(1, 8'h21);
    wait_start();
    repeat (10) cyc();
    chk("lvl_busy", busy, 1);
    chk("lvl_tout", timeout_err, 0);
    uart_tx_done = 1'b0;
    cyc();
    chk("lvl_busy2", busy, 1);
    uart_tx_done = 1'b1;
    cyc();
    cyc();
    chk("lvl_idle", busy, 0);
    done_hold = 0;
    tx_mute = 0;
    uart_tx_done = 1'b0;
    repeat (2) cyc();

`ifdef TX_TIMEOUT_EN
    // Watchdog expiry then next requester served
    tx_mute = 1;
    req(2, 8'h52);
    wait_start();
    req(3, 8'h53);
    for (k = 1; k < 200; k++) begin
      cyc();
      if (timeout_err === 1'b1) break;
    end
    chk("to_lat", k, 51);
    chk("to_idle", busy, 0);
    cyc();
    chk("to_1cyc", timeout_err, 0);
    tx_mute = 0;
    wait_start();
    wait_idle();
    chk("to_sb", sb.size(), 0);
`endif

    // Reset during WAIT, then req0 beats req3
    req(2, 8'h62);
    wait_start();
    cyc();
    chk("t6_inwait", busy, 1);
    do_reset();
    cyc();
    req(0, 8'h70);
    req(3, 8'h73);
    cyc();
    chk("t6_ready", req_ready, 4'b0001);
    wait_start();
    wait_start();
    wait_idle();
    chk("t6_sb", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
